// File: rtl/lfsr_pkg.sv
// Shared definitions for the BIST LFSR engine: run-FSM state encoding and the
// single-step LFSR/MISR next-state function.
package lfsr_pkg;

    // Widest register the next-state helper supports (NBIT must stay below this).
    localparam int LFSR_MAXW = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // One Fibonacci step toward the MSB. Operands are zero-extended by the
    // caller, so unused upper tap bits never reach the feedback. In PRPG mode
    // an all-zero register gets a forced 1 so the generator cannot lock up.
    function automatic logic [LFSR_MAXW-1:0] lfsr_next(
        input logic [LFSR_MAXW-1:0] dff,
        input logic [LFSR_MAXW-1:0] taps,
        input logic                 misr,
        input logic [LFSR_MAXW-1:0] din
    );
        logic                 fb;
        logic [LFSR_MAXW-1:0] shl;
        fb = ^(dff & taps);
        if (!misr && (dff == '0)) begin
            fb = 1'b1;
        end
        shl = {dff[LFSR_MAXW-2:0], fb};
        if (misr) begin
            shl = shl ^ din;
        end
        return shl;
    endfunction

endpackage

// File: rtl/lfsr_bist_ctrl.sv
// Run controller for the BIST LFSR: IDLE/RUN/DONE sequencing, pattern counter,
// latched mode and the end-of-run signature verdict.
module lfsr_bist_ctrl
    import lfsr_pkg::*;
#(
    parameter int NPAT = 15,
    parameter int CNTW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_scan_en,
    input  logic i_mode,
    input  logic i_sig_match,
    output logic o_load,
    output logic o_step,
    output logic o_mode_q,
    output logic o_busy,
    output logic o_done,
    output logic o_sig_ok
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NPAT - 1);

    logic [1:0]      r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_mode_q;
    logic            r_done;
    logic            r_sig_ok;
    logic            w_load;
    logic            w_step;

    // Scan shifting freezes the controller; otherwise start re-arms from
    // IDLE/DONE and every RUN cycle is one counted step.
    always_comb begin
        w_load = !i_scan_en && i_start && (r_state != S_RUN);
        w_step = !i_scan_en && (r_state == S_RUN);
    end

    // State, counter, mode latch and verdict; the last step reports from the
    // post-step register value supplied by the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mode_q <= 1'b0;
            r_done   <= 1'b0;
            r_sig_ok <= 1'b0;
        end else if (w_load) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_mode_q <= i_mode;
            r_done   <= 1'b0;
            r_sig_ok <= 1'b0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_sig_ok <= i_sig_match;
            end
        end
    end

    assign o_load   = w_load;
    assign o_step   = w_step;
    assign o_mode_q = r_mode_q;
    assign o_busy   = (r_state == S_RUN);
    assign o_done   = r_done;
    assign o_sig_ok = r_sig_ok;

endmodule

// File: rtl/lfsr_bist_engine.sv
// NBIT-wide Fibonacci LFSR BIST engine: PRPG pattern generation or MISR
// response compaction, bounded runs with golden-signature compare, and a
// serial scan override that keeps the register on the scan chain.
module lfsr_bist_engine
    import lfsr_pkg::*;
#(
    parameter int              NBIT   = 4,
    parameter logic [NBIT-1:0] TAPS   = 4'hC,
    parameter logic [NBIT-1:0] SEED   = 4'hF,
    parameter int              NPAT   = 15,
    parameter int              CNTW   = 4,
    parameter logic [NBIT-1:0] GOLDEN = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            scan_en,
    input  logic            scan_in,
    input  logic [NBIT-1:0] data_in,
    output logic [NBIT-1:0] out,
    output logic            scan_out,
    output logic            busy,
    output logic            done,
    output logic            sig_ok
);

    logic [NBIT-1:0]                r_dff;
    logic [LFSR_MAXW-1:0]           w_dff_x;
    logic [LFSR_MAXW-1:0]           w_taps_x;
    logic [LFSR_MAXW-1:0]           w_din_x;
    logic [LFSR_MAXW-1:0]           w_next_x;
    logic [NBIT-1:0]                w_next;
    logic [LFSR_MAXW-1:NBIT]        w_unused_hi;
    logic                           w_load;
    logic                           w_step;
    logic                           w_mode_q;
    logic                           w_sig_match;

    // Zero-extend the register, taps and response word for the shared step function.
    always_comb begin
        w_dff_x             = '0;
        w_dff_x[NBIT-1:0]   = r_dff;
        w_taps_x            = '0;
        w_taps_x[NBIT-1:0]  = TAPS;
        w_din_x             = '0;
        w_din_x[NBIT-1:0]   = data_in;
    end

    assign w_next_x    = lfsr_next(w_dff_x, w_taps_x, w_mode_q, w_din_x);
    assign w_next      = w_next_x[NBIT-1:0];
    assign w_unused_hi = w_next_x[LFSR_MAXW-1:NBIT];
    assign w_sig_match = (w_next == GOLDEN);

    lfsr_bist_ctrl #(
        .NPAT (NPAT),
        .CNTW (CNTW)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_scan_en   (scan_en),
        .i_mode      (mode),
        .i_sig_match (w_sig_match),
        .o_load      (w_load),
        .o_step      (w_step),
        .o_mode_q    (w_mode_q),
        .o_busy      (busy),
        .o_done      (done),
        .o_sig_ok    (sig_ok)
    );

    // Register update with priority scan shift > seed load > run step > hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dff <= SEED;
        end else if (scan_en) begin
            r_dff <= {r_dff[NBIT-2:0], scan_in};
        end else if (w_load) begin
            r_dff <= SEED;
        end else if (w_step) begin
            r_dff <= w_next;
        end
    end

    assign out      = r_dff;
    assign scan_out = r_dff[NBIT-1];

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Directed bench for lfsr_bist_engine with a behavioural reference model.
module tb_lfsr_bist_engine;

    localparam int              NBIT   = 4;
    localparam logic [NBIT-1:0] TAPS   = 4'hC;
    localparam logic [NBIT-1:0] SEED   = 4'hF;
    localparam int              NPAT   = 15;
    localparam int              CNTW   = 4;
    localparam logic [NBIT-1:0] GOLDEN = 4'hF;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic            scan_en = 1'b0;
    logic            scan_in = 1'b0;
    logic [NBIT-1:0] data_in = '0;
    logic [NBIT-1:0] out;
    logic            scan_out;
    logic            busy;
    logic            done;
    logic            sig_ok;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_bist_engine #(
        .NBIT(NBIT), .TAPS(TAPS), .SEED(SEED),
        .NPAT(NPAT), .CNTW(CNTW), .GOLDEN(GOLDEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .scan_en(scan_en), .scan_in(scan_in), .data_in(data_in),
        .out(out), .scan_out(scan_out), .busy(busy), .done(done), .sig_ok(sig_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is "steps remaining"; next value from parity of tapped bits.
    logic [NBIT-1:0] m_reg  = SEED;
    logic            m_run  = 1'b0;
    logic            m_done = 1'b0;
    logic            m_sig  = 1'b0;
    logic            m_mode = 1'b0;
    int              m_left = 0;

    always @(posedge clk or negedge rst) begin : model
        logic [NBIT-1:0] nxt;
        logic            par;
        if (!rst) begin
            m_reg <= SEED; m_run <= 1'b0; m_done <= 1'b0;
            m_sig <= 1'b0; m_mode <= 1'b0; m_left <= 0;
        end else if (scan_en) begin
            m_reg <= {m_reg[NBIT-2:0], scan_in};
        end else if (start && !m_run) begin
            m_reg <= SEED; m_run <= 1'b1; m_left <= NPAT;
            m_done <= 1'b0; m_sig <= 1'b0; m_mode <= mode;
        end else if (m_run) begin
            par = ($countones(m_reg & TAPS) % 2) == 1;
            if (!m_mode && m_reg == '0) par = 1'b1;
            nxt = m_reg << 1;
            nxt[0] = par;
            if (m_mode) nxt = nxt ^ data_in;
            m_reg  <= nxt;
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_run <= 1'b0; m_done <= 1'b1; m_sig <= (nxt == GOLDEN);
            end
        end
    end

    // Every out-of-reset cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("model_out",      32'(out),      32'(m_reg));
            check("model_scan_out", 32'(scan_out), 32'(m_reg[NBIT-1]));
            check("model_busy",     32'(busy),     32'(m_run));
            check("model_done",     32'(done),     32'(m_done));
            check("model_sig_ok",   32'(sig_ok),   32'(m_sig));
        end
    end

    task automatic wait_done(input int max_cyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("wait_done_timeout", 32'(done), 32'd1);
    endtask

    logic [NBIT-1:0] prpg_seq [16] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                       4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
    logic [NBIT-1:0] misr_seq [16] = '{4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4,
                                       4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    logic [3:0]      scan_bits = 4'b1010;
    logic [NBIT-1:0] scan_exp [4] = '{4'hE, 4'hD, 4'hA, 4'h5};
    logic            scan_oexp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig_ok", 32'(sig_ok), 32'd0);
        rst = 1'b1;

        // PRPG run
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        check("prpg_seed", 32'(out), 32'hF);
        check("prpg_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("prpg_step%0d", i), 32'(out), 32'(prpg_seq[i]));
            if (i < 15) check("prpg_not_done", 32'(done), 32'd0);
        end
        check("prpg_done", 32'(done), 32'd1);
        check("prpg_sig_ok", 32'(sig_ok), 32'd1);
        check("prpg_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_hold_out", 32'(out), 32'hF);

        // MISR run, re-armed from DONE
        start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0; data_in = 4'h1;
        check("misr_seed", 32'(out), 32'hF);
        check("rearm_done_clr", 32'(done), 32'd0);
        @(negedge clk); data_in = 4'h0;
        for (int i = 1; i < 16; i++) begin
            if (i > 1) @(negedge clk);
            check($sformatf("misr_step%0d", i), 32'(out), 32'(misr_seq[i]));
        end
        check("misr_done", 32'(done), 32'd1);
        check("misr_sig_ok", 32'(sig_ok), 32'd0);

        // Scan shift from reset value
        rst = 1'b0; mode = 1'b0;
        @(negedge clk); rst = 1'b1; scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scan_in = scan_bits[i];
            @(negedge clk);
            check($sformatf("scan_out_val%0d", i), 32'(out), 32'(scan_exp[i]));
            check($sformatf("scan_so%0d", i), 32'(scan_out), 32'(scan_oexp[i]));
            check("scan_busy", 32'(busy), 32'd0);
        end
        scan_en = 1'b0;

        // Scan stalls a run: 3 steps, 2 shifts, then 12 more steps to DONE
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_pre", 32'(out), 32'h8);
        scan_en = 1'b1; scan_in = 1'b1;
        repeat (2) @(negedge clk);
        scan_en = 1'b0;
        check("stall_shift", 32'(out), 32'h3);
        repeat (11) @(negedge clk);
        check("stall_not_done", 32'(done), 32'd0);
        @(negedge clk);
        check("stall_done", 32'(done), 32'd1);

        // Lock-up guard: zero scanned into a running PRPG
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        scan_en = 1'b1; scan_in = 1'b0;
        repeat (4) @(negedge clk);
        scan_en = 1'b0;
        check("lock_zero", 32'(out), 32'h0);
        @(negedge clk);
        check("lock_escape", 32'(out), 32'h1);
        wait_done(20);

        // Start in RUN ignored, then abort at cnt=7
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("run_start_ignored", 32'(out), 32'h8);
        repeat (4) @(negedge clk);
        check("abort_pre", 32'(out), 32'h9);
        @(posedge clk); #2 rst = 1'b0; #1;
        check("abort_out", 32'(out), 32'hF);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sig_ok", 32'(sig_ok), 32'd0);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);

        // Full run then re-arm from DONE
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(20);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("rearm2_out", 32'(out), 32'hF);
        check("rearm2_done", 32'(done), 32'd0);
        wait_done(20);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
